// File: rtl/contador_etapas_param.sv
// Parametrised instruction-step sequencer: tracks control step T0..Tn of the
// executing instruction with stall, early clear, completion pulse, one-hot
// step decode and sticky error flags.
module contador_etapas_param #(
    parameter int unsigned STEP_W   = 2,
    parameter int unsigned LAST_MAX = 3
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic                   Run,
    input  logic                   Clear,
    input  logic                   Stall,
    input  logic [STEP_W-1:0]      LastStep,
    input  logic                   ErrClr,
    output logic [STEP_W-1:0]      Tstep,
    output logic [2**STEP_W-1:0]   StepOH,
    output logic                   Busy,
    output logic                   Done,
    output logic [1:0]             Err
);

    localparam int unsigned       NSTEP      = 2 ** STEP_W;
    localparam logic [STEP_W-1:0] LAST_MAX_C = STEP_W'(LAST_MAX);

    typedef enum logic {
        S_IDLE,
        S_EXEC
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   tstep_q, tstep_d;
    logic [STEP_W-1:0]   last_q,  last_d;
    logic                done_q,  done_d;
    logic [1:0]          err_q,   err_d;

    logic                over_max;
    logic [STEP_W-1:0]   last_load;
    logic                complete;

    // Clamp the requested last step to the legal maximum.
    always_comb begin
        over_max  = (LastStep > LAST_MAX_C);
        last_load = over_max ? LAST_MAX_C : LastStep;
    end

    // Next-state: Clear beats Stall beats advance; a completing edge may
    // restart immediately when Run is high.
    always_comb begin
        state_d  = state_q;
        tstep_d  = tstep_q;
        last_d   = last_q;
        done_d   = 1'b0;
        err_d    = ErrClr ? 2'b00 : err_q;
        complete = 1'b0;

        case (state_q)
            S_IDLE: begin
                tstep_d = '0;
                if (Run) begin
                    state_d = S_EXEC;
                    last_d  = last_load;
                    if (over_max) err_d[1] = 1'b1;
                end
            end
            S_EXEC: begin
                complete = Clear || (!Stall && (tstep_q == last_q));
                if (complete) begin
                    done_d  = 1'b1;
                    tstep_d = '0;
                    if (Run) begin
                        last_d = last_load;
                        if (over_max) err_d[1] = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (Run) err_d[0] = 1'b1;
                    if (!Stall) tstep_d = tstep_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            tstep_q <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            tstep_q <= tstep_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // One-hot step decode, all zeros while idle.
    always_comb begin
        StepOH = '0;
        for (int unsigned i = 0; i < NSTEP; i++) begin
            StepOH[i] = (state_q == S_EXEC) && (tstep_q == STEP_W'(i));
        end
    end

    assign Tstep = tstep_q;
    assign Busy  = (state_q == S_EXEC);
    assign Done  = done_q;
    assign Err   = err_q;

endmodule

// File: tb/tb_contador_etapas_param.sv
// Bench for contador_etapas_param: three instances (default, narrow LAST_MAX,
// wide STEP_W) share stimulus; a per-instance model is checked every cycle,
// plus directed literal expectations.
module tb_contador_etapas_param;

    logic       Clock  = 1'b0;
    logic       Resetn = 1'b1;
    logic       Run    = 1'b0;
    logic       Clear  = 1'b0;
    logic       Stall  = 1'b0;
    logic       ErrClr = 1'b0;
    logic [2:0] LastStep = 3'd0;

    logic [1:0] t_a, t_c, err_a, err_b, err_c;
    logic [2:0] t_b;
    logic [3:0] oh_a, oh_c;
    logic [7:0] oh_b;
    logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 Clock = ~Clock;

    contador_etapas_param #(.STEP_W(2), .LAST_MAX(3)) dut_a (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .Clear(Clear), .Stall(Stall),
        .LastStep(LastStep[1:0]), .ErrClr(ErrClr), .Tstep(t_a), .StepOH(oh_a),
        .Busy(busy_a), .Done(done_a), .Err(err_a));

    contador_etapas_param #(.STEP_W(3), .LAST_MAX(7)) dut_b (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .Clear(Clear), .Stall(Stall),
        .LastStep(LastStep), .ErrClr(ErrClr), .Tstep(t_b), .StepOH(oh_b),
        .Busy(busy_b), .Done(done_b), .Err(err_b));

    contador_etapas_param #(.STEP_W(2), .LAST_MAX(2)) dut_c (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .Clear(Clear), .Stall(Stall),
        .LastStep(LastStep[1:0]), .ErrClr(ErrClr), .Tstep(t_c), .StepOH(oh_c),
        .Busy(busy_c), .Done(done_c), .Err(err_c));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: instance index 0=a, 1=b, 2=c.
    int       lmax[3] = '{3, 7, 2};
    bit       m_busy[3];
    int       m_step[3];
    int       m_last[3];
    bit       m_done[3];
    bit [1:0] m_err[3];

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k < 3; k++) begin
                m_busy[k] <= 1'b0; m_step[k] <= 0; m_last[k] <= 0;
                m_done[k] <= 1'b0; m_err[k]  <= 2'b00;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                automatic int ls     = (k == 1) ? int'(LastStep) : int'(LastStep[1:0]);
                automatic bit fin    = m_busy[k] && (Clear || (!Stall && m_step[k] == m_last[k]));
                automatic bit start  = Run && (!m_busy[k] || fin);
                automatic bit [1:0] e = ErrClr ? 2'b00 : m_err[k];
                if (m_busy[k] && Run && !fin) e[0] = 1'b1;
                if (start && ls > lmax[k]) e[1] = 1'b1;
                m_err[k]  <= e;
                m_done[k] <= fin;
                if (start) begin
                    m_busy[k] <= 1'b1;
                    m_step[k] <= 0;
                    m_last[k] <= (ls > lmax[k]) ? lmax[k] : ls;
                end else if (fin) begin
                    m_busy[k] <= 1'b0;
                    m_step[k] <= 0;
                end else if (m_busy[k] && !Stall) begin
                    m_step[k] <= m_step[k] + 1;
                end
            end
        end
    end

    int d_t[3], d_oh[3], d_busy[3], d_done[3], d_err[3];
    always_comb begin
        d_t[0] = int'(t_a);  d_oh[0] = int'(oh_a); d_busy[0] = int'(busy_a);
        d_t[1] = int'(t_b);  d_oh[1] = int'(oh_b); d_busy[1] = int'(busy_b);
        d_t[2] = int'(t_c);  d_oh[2] = int'(oh_c); d_busy[2] = int'(busy_c);
        d_done[0] = int'(done_a); d_err[0] = int'(err_a);
        d_done[1] = int'(done_b); d_err[1] = int'(err_b);
        d_done[2] = int'(done_c); d_err[2] = int'(err_c);
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge Clock) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model_tstep[%0d]", k), d_t[k], m_step[k]);
                chk($sformatf("model_steposh[%0d]", k), d_oh[k], m_busy[k] ? (1 << m_step[k]) : 0);
                chk($sformatf("model_busy[%0d]", k), d_busy[k], int'(m_busy[k]));
                chk($sformatf("model_done[%0d]", k), d_done[k], int'(m_done[k]));
                chk($sformatf("model_err[%0d]", k), d_err[k], int'(m_err[k]));
            end
        end
    end

    task automatic cyc();
        @(negedge Clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 Resetn = 1'b0;
        #1;
        chk("reset_busy", int'(busy_a), 0);
        chk("reset_oh", int'(oh_a), 0);
        cyc();
        Resetn = 1'b1;
        chk_en = 1'b1;
        cyc();

        // Basic run, LastStep=3.
        Run = 1'b1; LastStep = 3'd3;
        cyc(); Run = 1'b0;
        chk("basic_t0", int'(t_a), 0); chk("basic_oh0", int'(oh_a), 1);
        chk("basic_busy", int'(busy_a), 1);
        chk("clamp_err_c", int'(err_c), 2);
        cyc(); chk("basic_t1", int'(t_a), 1); chk("basic_oh1", int'(oh_a), 2);
        cyc(); chk("basic_t2", int'(t_a), 2); chk("basic_oh2", int'(oh_a), 4);
        cyc(); chk("basic_t3", int'(t_a), 3); chk("basic_oh3", int'(oh_a), 8);
        chk("clamp_done_c", int'(done_c), 1);
        cyc(); chk("basic_done", int'(done_a), 1); chk("basic_idle", int'(busy_a), 0);
        chk("basic_tidle", int'(t_a), 0);
        ErrClr = 1'b1;
        cyc(); ErrClr = 1'b0;
        chk("basic_done_low", int'(done_a), 0);
        chk("errclr_c", int'(err_c), 0);

        // Clear/Stall ignored in idle.
        Clear = 1'b1; Stall = 1'b1;
        cyc(); cyc();
        chk("idle_ignore", int'(busy_a), 0);
        Clear = 1'b0; Stall = 1'b0;

        // Stall then Clear-under-Stall.
        Run = 1'b1; LastStep = 3'd3;
        cyc(); Run = 1'b0;
        cyc(); chk("stall_t1a", int'(t_a), 1); Stall = 1'b1;
        cyc(); chk("stall_t1b", int'(t_a), 1);
        cyc(); chk("stall_t1c", int'(t_a), 1); Stall = 1'b0;
        cyc(); chk("stall_t2", int'(t_a), 2); Stall = 1'b1; Clear = 1'b1;
        cyc(); Stall = 1'b0; Clear = 1'b0;
        chk("clear_done", int'(done_a), 1); chk("clear_idle", int'(busy_a), 0);
        cyc();

        // Back-to-back.
        Run = 1'b1; LastStep = 3'd1;
        cyc(); Run = 1'b0; chk("b2b_t0", int'(t_a), 0);
        cyc(); chk("b2b_t1", int'(t_a), 1); Run = 1'b1; LastStep = 3'd2;
        cyc(); Run = 1'b0;
        chk("b2b_restart_t", int'(t_a), 0); chk("b2b_busy", int'(busy_a), 1);
        chk("b2b_done1", int'(done_a), 1); chk("b2b_noerr", int'(err_a), 0);
        cyc(); chk("b2b_t1b", int'(t_a), 1); chk("b2b_done_low", int'(done_a), 0);
        cyc(); chk("b2b_t2", int'(t_a), 2);
        cyc(); chk("b2b_done2", int'(done_a), 1); chk("b2b_end", int'(busy_a), 0);

        // Run while busy.
        Run = 1'b1; LastStep = 3'd3;
        cyc(); Run = 1'b0;
        cyc(); chk("errrun_t1", int'(t_a), 1); Run = 1'b1;
        cyc(); Run = 1'b0;
        chk("errrun_t2", int'(t_a), 2); chk("errrun_err", int'(err_a), 1);
        chk("errrun_err_c", int'(err_c), 3);
        cyc(); cyc(); cyc();
        // ErrClr on the same edge as a clamp set event.
        ErrClr = 1'b1; Run = 1'b1; LastStep = 3'd3;
        cyc(); ErrClr = 1'b0; Run = 1'b0;
        chk("errclr_a", int'(err_a), 0); chk("setwins_c", int'(err_c), 2);
        repeat (6) cyc();

        // Wide instance: LastStep=7 walks all eight steps.
        Run = 1'b1; LastStep = 3'd7;
        cyc(); Run = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wide_t%0d", i), int'(t_b), i);
            chk($sformatf("wide_oh%0d", i), int'(oh_b), 1 << i);
            cyc();
        end
        chk("wide_done", int'(done_b), 1); chk("wide_idle", int'(busy_b), 0);
        cyc();
        Run = 1'b1; LastStep = 3'd0;
        cyc(); Run = 1'b0;
        chk("single_busy", int'(busy_b), 1); chk("single_t", int'(t_b), 0);
        cyc(); chk("single_done", int'(done_b), 1); chk("single_idle", int'(busy_b), 0);
        cyc();

        // Asynchronous reset mid-instruction at Tstep=2 with Err set.
        Run = 1'b1; LastStep = 3'd3;
        cyc(); Run = 1'b0;
        cyc(); Run = 1'b1;
        cyc(); Run = 1'b0;
        chk("prereset_t2", int'(t_a), 2); chk("prereset_err", int'(err_a), 1);
        #2 Resetn = 1'b0;
        #1;
        chk("areset_t", int'(t_a), 0); chk("areset_busy", int'(busy_a), 0);
        chk("areset_done", int'(done_a), 0); chk("areset_err", int'(err_a), 0);
        chk("areset_oh", int'(oh_a), 0);
        cyc(); Resetn = 1'b1;
        cyc(); chk("postreset_done", int'(done_a), 0); chk("postreset_busy", int'(busy_a), 0);
        cyc();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
